// File: rtl/id_exe_register.sv
// rtl/id_exe_register.sv - ID/EXE pipeline register with condition annul, freeze, flush and debug counters
// Side-effect controls are gated by valid_in & cond_pass so an annulled instruction moves on as a valid NOP.
module id_exe_register #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             flush,
  input  logic             valid_in,
  input  logic             cond_pass,
  input  logic [31:0]      pc_in,
  input  logic [31:0]      val_rn_in,
  input  logic [31:0]      val_rm_in,
  input  logic [3:0]       exe_cmd_in,
  input  logic             wb_en_in,
  input  logic             mem_r_en_in,
  input  logic             mem_w_en_in,
  input  logic             s_in,
  input  logic             b_in,
  input  logic             imm_in,
  input  logic [11:0]      shift_operand_in,
  input  logic [23:0]      signed_imm24_in,
  input  logic [3:0]       dest_in,
  input  logic [3:0]       src1_in,
  input  logic [3:0]       src2_in,
  input  logic [3:0]       status_in,
  output logic             valid_out,
  output logic [31:0]      pc_out,
  output logic [31:0]      val_rn_out,
  output logic [31:0]      val_rm_out,
  output logic [3:0]       exe_cmd_out,
  output logic             wb_en_out,
  output logic             mem_r_en_out,
  output logic             mem_w_en_out,
  output logic             s_out,
  output logic             b_out,
  output logic             imm_out,
  output logic [11:0]      shift_operand_out,
  output logic [23:0]      signed_imm24_out,
  output logic [3:0]       dest_out,
  output logic [3:0]       src1_out,
  output logic [3:0]       src2_out,
  output logic             carry_out,
  output logic [CNT_W-1:0] annul_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] val_rn;
    logic [31:0] val_rm;
    logic [3:0]  exe_cmd;
    logic        wb_en;
    logic        mem_r_en;
    logic        mem_w_en;
    logic        s;
    logic        b;
    logic        imm;
    logic [11:0] shift_operand;
    logic [23:0] signed_imm24;
    logic [3:0]  dest;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic        carry;
  } stage_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  stage_t           stage_q, stage_d;
  logic [CNT_W-1:0] annul_cnt_q, annul_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             exec_ok;

  assign exec_ok = valid_in & cond_pass;

  always_comb begin
    stage_d     = stage_q;
    annul_cnt_d = annul_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (flush) begin
      stage_d = '0;
      if (valid_in && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_ONE;
    end else if (!freeze) begin
      stage_d.valid         = valid_in;
      stage_d.pc            = pc_in;
      stage_d.val_rn        = val_rn_in;
      stage_d.val_rm        = val_rm_in;
      stage_d.exe_cmd       = exe_cmd_in;
      stage_d.wb_en         = wb_en_in & exec_ok;
      stage_d.mem_r_en      = mem_r_en_in & exec_ok;
      stage_d.mem_w_en      = mem_w_en_in & exec_ok;
      stage_d.s             = s_in & exec_ok;
      stage_d.b             = b_in & exec_ok;
      stage_d.imm           = imm_in;
      stage_d.shift_operand = shift_operand_in;
      stage_d.signed_imm24  = signed_imm24_in;
      stage_d.dest          = dest_in;
      stage_d.src1          = src1_in;
      stage_d.src2          = src2_in;
      stage_d.carry         = status_in[1];
      if (valid_in && !cond_pass && (annul_cnt_q != '1)) annul_cnt_d = annul_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_q     <= '0;
      annul_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stage_q     <= stage_d;
      annul_cnt_q <= annul_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign valid_out         = stage_q.valid;
  assign pc_out            = stage_q.pc;
  assign val_rn_out        = stage_q.val_rn;
  assign val_rm_out        = stage_q.val_rm;
  assign exe_cmd_out       = stage_q.exe_cmd;
  assign wb_en_out         = stage_q.wb_en;
  assign mem_r_en_out      = stage_q.mem_r_en;
  assign mem_w_en_out      = stage_q.mem_w_en;
  assign s_out             = stage_q.s;
  assign b_out             = stage_q.b;
  assign imm_out           = stage_q.imm;
  assign shift_operand_out = stage_q.shift_operand;
  assign signed_imm24_out  = stage_q.signed_imm24;
  assign dest_out          = stage_q.dest;
  assign src1_out          = stage_q.src1;
  assign src2_out          = stage_q.src2;
  assign carry_out         = stage_q.carry;
  assign annul_cnt         = annul_cnt_q;
  assign flush_cnt         = flush_cnt_q;

endmodule

// File: tb/tb_id_exe_register.sv
// tb/tb_id_exe_register.sv - randomized and directed bench for id_exe_register against a behavioural model
module tb_id_exe_register;
  localparam int CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic freeze, flush, valid_in, cond_pass;
  logic [31:0] pc_in, val_rn_in, val_rm_in;
  logic [3:0] exe_cmd_in, dest_in, src1_in, src2_in, status_in;
  logic wb_en_in, mem_r_en_in, mem_w_en_in, s_in, b_in, imm_in;
  logic [11:0] shift_operand_in;
  logic [23:0] signed_imm24_in;

  logic valid_out, wb_en_out, mem_r_en_out, mem_w_en_out, s_out, b_out, imm_out, carry_out;
  logic [31:0] pc_out, val_rn_out, val_rm_out;
  logic [3:0] exe_cmd_out, dest_out, src1_out, src2_out;
  logic [11:0] shift_operand_out;
  logic [23:0] signed_imm24_out;
  logic [CNT_W-1:0] annul_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  // Expected EXE-side view of the instruction, kept as plain variables.
  logic m_valid = 0, m_wb = 0, m_mr = 0, m_mw = 0, m_s = 0, m_b = 0, m_imm = 0, m_carry = 0;
  logic [31:0] m_pc = 0, m_rn = 0, m_rm = 0;
  logic [3:0] m_cmd = 0, m_dest = 0, m_src1 = 0, m_src2 = 0;
  logic [11:0] m_shift = 0;
  logic [23:0] m_imm24 = 0;
  int m_ac = 0, m_fc = 0;

  id_exe_register #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .valid_in(valid_in), .cond_pass(cond_pass), .pc_in(pc_in),
    .val_rn_in(val_rn_in), .val_rm_in(val_rm_in), .exe_cmd_in(exe_cmd_in),
    .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
    .s_in(s_in), .b_in(b_in), .imm_in(imm_in),
    .shift_operand_in(shift_operand_in), .signed_imm24_in(signed_imm24_in),
    .dest_in(dest_in), .src1_in(src1_in), .src2_in(src2_in), .status_in(status_in),
    .valid_out(valid_out), .pc_out(pc_out), .val_rn_out(val_rn_out), .val_rm_out(val_rm_out),
    .exe_cmd_out(exe_cmd_out), .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out),
    .mem_w_en_out(mem_w_en_out), .s_out(s_out), .b_out(b_out), .imm_out(imm_out),
    .shift_operand_out(shift_operand_out), .signed_imm24_out(signed_imm24_out),
    .dest_out(dest_out), .src1_out(src1_out), .src2_out(src2_out), .carry_out(carry_out),
    .annul_cnt(annul_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_valid = 0; m_wb = 0; m_mr = 0; m_mw = 0; m_s = 0; m_b = 0; m_imm = 0; m_carry = 0;
    m_pc = 0; m_rn = 0; m_rm = 0; m_cmd = 0; m_dest = 0; m_src1 = 0; m_src2 = 0;
    m_shift = 0; m_imm24 = 0;
  endtask

  task automatic compare_all();
    chk("valid_out", 32'(valid_out), 32'(m_valid));
    chk("pc_out", pc_out, m_pc);
    chk("val_rn_out", val_rn_out, m_rn);
    chk("val_rm_out", val_rm_out, m_rm);
    chk("exe_cmd_out", 32'(exe_cmd_out), 32'(m_cmd));
    chk("wb_en_out", 32'(wb_en_out), 32'(m_wb));
    chk("mem_r_en_out", 32'(mem_r_en_out), 32'(m_mr));
    chk("mem_w_en_out", 32'(mem_w_en_out), 32'(m_mw));
    chk("s_out", 32'(s_out), 32'(m_s));
    chk("b_out", 32'(b_out), 32'(m_b));
    chk("imm_out", 32'(imm_out), 32'(m_imm));
    chk("shift_operand_out", 32'(shift_operand_out), 32'(m_shift));
    chk("signed_imm24_out", 32'(signed_imm24_out), 32'(m_imm24));
    chk("dest_out", 32'(dest_out), 32'(m_dest));
    chk("src1_out", 32'(src1_out), 32'(m_src1));
    chk("src2_out", 32'(src2_out), 32'(m_src2));
    chk("carry_out", 32'(carry_out), 32'(m_carry));
    chk("annul_cnt", 32'(annul_cnt), 32'(m_ac));
    chk("flush_cnt", 32'(flush_cnt), 32'(m_fc));
  endtask

  always @(negedge rst) begin
    model_clear();
    m_ac = 0;
    m_fc = 0;
  end

  // Model update from the inputs present at the edge, then compare just after it.
  always @(posedge clk) begin
    if (rst === 1'b1) begin
      if (flush) begin
        model_clear();
        if (valid_in && m_fc < CNT_MAX) m_fc++;
      end else if (!freeze) begin
        m_valid = valid_in;
        m_pc = pc_in; m_rn = val_rn_in; m_rm = val_rm_in; m_cmd = exe_cmd_in;
        m_imm = imm_in; m_shift = shift_operand_in; m_imm24 = signed_imm24_in;
        m_dest = dest_in; m_src1 = src1_in; m_src2 = src2_in; m_carry = status_in[1];
        if (valid_in && cond_pass) begin
          m_wb = wb_en_in; m_mr = mem_r_en_in; m_mw = mem_w_en_in; m_s = s_in; m_b = b_in;
        end else begin
          m_wb = 0; m_mr = 0; m_mw = 0; m_s = 0; m_b = 0;
        end
        if (valid_in && !cond_pass && m_ac < CNT_MAX) m_ac++;
      end
    end
    #1;
    compare_all();
  end

  task automatic clear_inputs();
    freeze = 0; flush = 0; valid_in = 0; cond_pass = 0;
    pc_in = 0; val_rn_in = 0; val_rm_in = 0; exe_cmd_in = 0;
    wb_en_in = 0; mem_r_en_in = 0; mem_w_en_in = 0; s_in = 0; b_in = 0; imm_in = 0;
    shift_operand_in = 0; signed_imm24_in = 0; dest_in = 0; src1_in = 0; src2_in = 0;
    status_in = 0;
  endtask

  task automatic random_fields();
    valid_in = ($urandom_range(0, 4) != 0);
    cond_pass = 1'($urandom);
    pc_in = $urandom; val_rn_in = $urandom; val_rm_in = $urandom;
    exe_cmd_in = 4'($urandom);
    wb_en_in = 1'($urandom); mem_r_en_in = 1'($urandom); mem_w_en_in = 1'($urandom);
    s_in = 1'($urandom); b_in = 1'($urandom); imm_in = 1'($urandom);
    shift_operand_in = 12'($urandom); signed_imm24_in = 24'($urandom);
    dest_in = 4'($urandom); src1_in = 4'($urandom); src2_in = 4'($urandom);
    status_in = 4'($urandom);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    clear_inputs();
    repeat (2) step();
    chk("reset_valid", 32'(valid_out), 32'h0);
    chk("reset_pc", pc_out, 32'h0);
    chk("reset_annul", 32'(annul_cnt), 32'h0);
    chk("reset_flush", 32'(flush_cnt), 32'h0);
    rst = 1;

    valid_in = 1; cond_pass = 1; wb_en_in = 1; mem_w_en_in = 1; dest_in = 4'hA; val_rn_in = 32'h12345678;
    step();
    chk("pass_valid", 32'(valid_out), 32'h1);
    chk("pass_wb", 32'(wb_en_out), 32'h1);
    chk("pass_mw", 32'(mem_w_en_out), 32'h1);
    chk("pass_dest", 32'(dest_out), 32'hA);
    chk("pass_rn", val_rn_out, 32'h12345678);
    chk("pass_annul", 32'(annul_cnt), 32'h0);

    cond_pass = 0; b_in = 1; s_in = 1;
    step();
    chk("fail_valid", 32'(valid_out), 32'h1);
    chk("fail_side", 32'({wb_en_out, mem_r_en_out, mem_w_en_out, s_out, b_out}), 32'h0);
    chk("fail_dest", 32'(dest_out), 32'hA);
    chk("fail_annul", 32'(annul_cnt), 32'h1);

    freeze = 1;
    for (int i = 0; i < 3; i++) begin
      random_fields();
      step();
      chk("frz_dest", 32'(dest_out), 32'hA);
      chk("frz_rn", val_rn_out, 32'h12345678);
      chk("frz_valid", 32'(valid_out), 32'h1);
      chk("frz_wb", 32'(wb_en_out), 32'h0);
      chk("frz_annul", 32'(annul_cnt), 32'h1);
    end
    flush = 1; valid_in = 1;
    step();
    chk("fl_valid", 32'(valid_out), 32'h0);
    chk("fl_ctrl", 32'({wb_en_out, mem_r_en_out, mem_w_en_out, s_out, b_out}), 32'h0);
    chk("fl_pc", pc_out, 32'h0);
    chk("fl_flush_cnt", 32'(flush_cnt), 32'h1);
    chk("fl_annul_cnt", 32'(annul_cnt), 32'h1);

    clear_inputs();
    valid_in = 1; cond_pass = 1; pc_in = 32'h00000010; wb_en_in = 1;
    step();
    chk("pre_rst_pc", pc_out, 32'h10);
    chk("pre_rst_wb", 32'(wb_en_out), 32'h1);
    rst = 0;
    #1;
    chk("mid_rst_pc", pc_out, 32'h0);
    chk("mid_rst_wb", 32'(wb_en_out), 32'h0);
    chk("mid_rst_valid", 32'(valid_out), 32'h0);
    chk("mid_rst_annul", 32'(annul_cnt), 32'h0);
    chk("mid_rst_flush", 32'(flush_cnt), 32'h0);
    rst = 1;

    clear_inputs();
    valid_in = 1; cond_pass = 1; status_in = 4'b0010;
    step();
    chk("carry_load", 32'(carry_out), 32'h1);
    freeze = 1; status_in = 4'b0000;
    repeat (2) begin
      step();
      chk("carry_hold", 32'(carry_out), 32'h1);
    end
    freeze = 0;
    step();
    chk("carry_reload", 32'(carry_out), 32'h0);

    clear_inputs();
    valid_in = 1; cond_pass = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (i == 9) chk("sat_mid", 32'(annul_cnt), 32'd10);
    end
    chk("sat_annul", 32'(annul_cnt), 32'hF);
    valid_in = 0; flush = 1;
    repeat (5) step();
    chk("inv_flush_cnt", 32'(flush_cnt), 32'h0);
    chk("inv_flush_annul", 32'(annul_cnt), 32'hF);

    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      random_fields();
      flush = ($urandom_range(0, 9) == 0);
      freeze = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 199) == 0) begin
        #1 rst = 0;
        #1;
        chk("rnd_rst_valid", 32'(valid_out), 32'h0);
        chk("rnd_rst_cnt", 32'({annul_cnt, flush_cnt}), 32'h0);
        rst = 1;
      end
    end
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
